serial_in_scanner: RTL and testbench



---
 rtl/serial_io_pkg.sv | 22 ++
 rtl/serial_in_scanner_if.sv | 26 ++
 rtl/serial_in_scanner_debounce_edge_cell.sv | 59 +++++
 rtl/serial_in_scanner.sv | 127 ++++++++++++
 tb/tb_serial_in_scanner.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_io_pkg.sv
// Shared types and constants for the 74LV165 serial input scanner.
package serial_io_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } scan_state_e;

   localparam int SER_CHAINS = 3;
   localparam int SER_BITS   = 24;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int clog2_min1(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/serial_in_scanner_if.sv
// Pin- and panel-side signal bundle of the serial input scanner.
interface serial_in_scanner_if #(
   parameter int CHAINS = serial_io_pkg::SER_CHAINS,
   parameter int BITS   = serial_io_pkg::SER_BITS
);
   logic                     enable;
   logic [CHAINS-1:0]        qh;
   logic                     shldn;
   logic                     srclk;
   logic                     clk_inh;
   logic [CHAINS*BITS-1:0]   raw;
   logic [CHAINS*BITS-1:0]   data;
   logic [CHAINS*BITS-1:0]   rise;
   logic [CHAINS*BITS-1:0]   fall;
   logic                     frame_done;

   modport master (
      input  enable, qh,
      output shldn, srclk, clk_inh, raw, data, rise, fall, frame_done
   );

   modport slave (
      output enable, qh,
      input  shldn, srclk, clk_inh, raw, data, rise, fall, frame_done
   );
endinterface

// File: rtl/serial_in_scanner_debounce_edge_cell.sv
// One input bit: frame-counting debounce with stable level and rise/fall pulses.
module debounce_edge_cell
   import serial_io_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic update_i,
   input  logic sample_i,
   output logic stable_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int            CW       = clog2_min1(DEBOUNCE_FRAMES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (update_i) begin
         if (sample_i == stable_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            stable_d = sample_i;
            cnt_d    = '0;
            rise_d   = sample_i;
            fall_d   = ~sample_i;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign stable_o = stable_q;
   assign rise_o   = rise_q;
   assign fall_o   = fall_q;
endmodule

// File: rtl/serial_in_scanner.sv
// Continuous scanner for CHAINS daisy-chained 74LV165 groups with per-bit
// debounce; raw/data/rise/fall all update on the edge that enters DONE.
module serial_in_scanner
   import serial_io_pkg::*;
#(
   parameter int CHAINS          = SER_CHAINS,
   parameter int BITS            = SER_BITS,
   parameter int DIV             = 4,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic                clk,
   input  logic                reset,
   serial_in_scanner_if.master bus
);
   localparam int            W        = CHAINS * BITS;
   localparam int            DW       = clog2_min1(DIV);
   localparam int            BW       = clog2_min1(BITS);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);

   scan_state_e                 state_q;
   logic [DW-1:0]               div_q;
   logic [BW-1:0]               bit_q;
   logic                        shldn_q, srclk_q, clk_inh_q, frame_done_q;
   logic [CHAINS-1:0][BITS-1:0] shreg_q;
   logic [W-1:0]                raw_q;

   logic         phase_end;
   logic         frame_end;
   logic [W-1:0] shreg_flat;
   logic [W-1:0] data_w, rise_w, fall_w;

   assign phase_end  = (div_q == DIV_LAST);
   // Last cycle of the final high phase: the shift registers hold a whole frame.
   assign frame_end  = (state_q == SHIFT) && phase_end && srclk_q && (bit_q == BIT_LAST);
   assign shreg_flat = shreg_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         div_q        <= '0;
         bit_q        <= '0;
         shldn_q      <= 1'b1;
         srclk_q      <= 1'b0;
         clk_inh_q    <= 1'b1;
         frame_done_q <= 1'b0;
         shreg_q      <= '0;
         raw_q        <= '0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.enable) begin
                  state_q <= LOAD;
                  div_q   <= '0;
                  shldn_q <= 1'b0;
               end
            end
            LOAD: begin
               if (phase_end) begin
                  state_q   <= SHIFT;
                  div_q     <= '0;
                  bit_q     <= '0;
                  shldn_q   <= 1'b1;
                  clk_inh_q <= 1'b0;
               end else begin
                  div_q <= div_q + DW'(1);
               end
            end
            SHIFT: begin
               if (!phase_end) begin
                  div_q <= div_q + DW'(1);
               end else begin
                  div_q   <= '0;
                  srclk_q <= ~srclk_q;
                  if (!srclk_q) begin
                     // MSB arrives first and ends up at the top after BITS shifts.
                     for (int c = 0; c < CHAINS; c++) begin
                        shreg_q[c] <= BITS'({shreg_q[c], bus.qh[c]});
                     end
                  end else if (bit_q == BIT_LAST) begin
                     state_q      <= DONE;
                     clk_inh_q    <= 1'b1;
                     raw_q        <= shreg_q;
                     frame_done_q <= 1'b1;
                  end else begin
                     bit_q <= bit_q + BW'(1);
                  end
               end
            end
            DONE: begin
               if (bus.enable) begin
                  state_q <= LOAD;
                  div_q   <= '0;
                  shldn_q <= 1'b0;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   for (genvar gi = 0; gi < W; gi++) begin : g_cell
      debounce_edge_cell #(
         .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
      ) u_cell (
         .clk     (clk),
         .reset   (reset),
         .update_i(frame_end),
         .sample_i(shreg_flat[gi]),
         .stable_o(data_w[gi]),
         .rise_o  (rise_w[gi]),
         .fall_o  (fall_w[gi])
      );
   end

   assign bus.shldn      = shldn_q;
   assign bus.srclk      = srclk_q;
   assign bus.clk_inh    = clk_inh_q;
   assign bus.raw        = raw_q;
   assign bus.data       = data_w;
   assign bus.rise       = rise_w;
   assign bus.fall       = fall_w;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_serial_in_scanner.sv
// Scanner bench: pin-level 74LV165 chain model driving two scanners
// (debounce depth 3 and 1) checked against a history-based debounce model.
module tb_serial_in_scanner;
   localparam int CH     = 2;
   localparam int BT     = 8;
   localparam int DV     = 2;
   localparam int DF     = 3;
   localparam int W      = CH * BT;
   localparam int PERIOD = DV + 2 * DV * BT + 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_in_scanner_if #(.CHAINS(CH), .BITS(BT)) bus_a ();
   serial_in_scanner_if #(.CHAINS(CH), .BITS(BT)) bus_b ();

   serial_in_scanner #(.CHAINS(CH), .BITS(BT), .DIV(DV), .DEBOUNCE_FRAMES(DF)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
   );
   serial_in_scanner #(.CHAINS(CH), .BITS(BT), .DIV(DV), .DEBOUNCE_FRAMES(1)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
   );

   // 74LV165 chains: parallel load while SH/LDn low, shift on SRCLK rise when not inhibited.
   logic [CH-1:0][BT-1:0] pat_a = '0, pat_b = '0, chip_a = '0, chip_b = '0;
   logic [CH-1:0]         qh_a, qh_b;
   logic                  sr_prev_a = 1'b0, sr_prev_b = 1'b0;

   always @(posedge clk) begin
      for (int c = 0; c < CH; c++) begin
         if (!bus_a.shldn) chip_a[c] <= pat_a[c];
         else if (!bus_a.clk_inh && bus_a.srclk && !sr_prev_a) chip_a[c] <= chip_a[c] << 1;
         if (!bus_b.shldn) chip_b[c] <= pat_b[c];
         else if (!bus_b.clk_inh && bus_b.srclk && !sr_prev_b) chip_b[c] <= chip_b[c] << 1;
      end
      sr_prev_a <= bus_a.srclk;
      sr_prev_b <= bus_b.srclk;
   end

   always_comb begin
      qh_a = '0;
      qh_b = '0;
      for (int c = 0; c < CH; c++) begin
         qh_a[c] = chip_a[c][BT-1];
         qh_b[c] = chip_b[c][BT-1];
      end
   end
   assign bus_a.qh = qh_a;
   assign bus_b.qh = qh_b;

   // Reference: a stable bit flips when the last `depth` frames all disagree with it.
   logic [W-1:0] m_data[2], m_rise[2], m_fall[2];
   logic [W-1:0] hist0[$], hist1[$];

   function automatic void ref_reset(input int inst);
      m_data[inst] = '0;
      m_rise[inst] = '0;
      m_fall[inst] = '0;
      if (inst == 0) hist0.delete();
      else hist1.delete();
   endfunction

   function automatic void ref_frame(input int inst, input int depth, input logic [W-1:0] s);
      logic [W-1:0] h[$];
      logic [W-1:0] d;
      bit run;
      if (inst == 0) begin
         hist0.push_back(s);
         while (hist0.size() > depth) void'(hist0.pop_front());
         h = hist0;
      end else begin
         hist1.push_back(s);
         while (hist1.size() > depth) void'(hist1.pop_front());
         h = hist1;
      end
      d = m_data[inst];
      m_rise[inst] = '0;
      m_fall[inst] = '0;
      for (int i = 0; i < W; i++) begin
         run = (h.size() == depth);
         for (int k = 0; k < h.size(); k++) if (h[k][i] == d[i]) run = 1'b0;
         if (run) begin
            m_rise[inst][i] = s[i];
            m_fall[inst][i] = ~s[i];
            d[i] = s[i];
         end
      end
      m_data[inst] = d;
   endfunction

   task automatic wait_fd(input int inst, input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (((inst == 0) ? bus_a.frame_done : bus_b.frame_done) === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         n_cmp++;
         if ((((bus_a.rise | bus_a.fall) != '0) && !bus_a.frame_done) || ((bus_a.rise & bus_a.fall) != '0)) begin
            n_fail++;
            $display("FAIL pulse_a: rise=%h fall=%h frame_done=%b, required no pulse outside DONE and never both",
                     bus_a.rise, bus_a.fall, bus_a.frame_done);
         end
         n_cmp++;
         if ((((bus_b.rise | bus_b.fall) != '0) && !bus_b.frame_done) || ((bus_b.rise & bus_b.fall) != '0)) begin
            n_fail++;
            $display("FAIL pulse_b: rise=%h fall=%h frame_done=%b, required no pulse outside DONE and never both",
                     bus_b.rise, bus_b.fall, bus_b.frame_done);
         end
      end
   end

   task automatic test_reset();
      n_cmp++;
      if ({bus_a.shldn, bus_a.srclk, bus_a.clk_inh, bus_a.frame_done} !== 4'b1010 ||
          {bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall} !== '0) begin
         n_fail++;
         $display("FAIL reset_a: pins %b%b%b fd=%b raw=%h data=%h rise=%h fall=%h, required 101 fd=0 all zero",
                  bus_a.shldn, bus_a.srclk, bus_a.clk_inh, bus_a.frame_done, bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall);
      end
      n_cmp++;
      if ({bus_b.shldn, bus_b.srclk, bus_b.clk_inh, bus_b.frame_done} !== 4'b1010 || {bus_b.raw, bus_b.data} !== '0) begin
         n_fail++;
         $display("FAIL reset_b: pins %b%b%b fd=%b raw=%h data=%h, required 101 fd=0 zero",
                  bus_b.shldn, bus_b.srclk, bus_b.clk_inh, bus_b.frame_done, bus_b.raw, bus_b.data);
      end
   endtask

   task automatic test_first_frames();
      bit ok;
      int last;
      logic [W-1:0] s;
      pat_a = {8'h3C, 8'hA5};
      s = pat_a;
      bus_a.enable = 1'b1;
      reset = 1'b0;
      last = 0;
      for (int f = 1; f <= 4; f++) begin
         wait_fd(0, 2 * PERIOD, ok);
         n_cmp++;
         if (!ok) begin n_fail++; $display("FAIL first_timeout frame %0d: no frame_done, required within %0d cycles", f, 2 * PERIOD); end
         ref_frame(0, DF, s);
         n_cmp++;
         if ({bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall} !== {s, m_data[0], m_rise[0], m_fall[0]}) begin
            n_fail++;
            $display("FAIL first_frame%0d: raw/data/rise/fall %h/%h/%h/%h, required %h/%h/%h/%h", f,
                     bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall, s, m_data[0], m_rise[0], m_fall[0]);
         end
         if (f == 3) begin
            n_cmp++;
            if (bus_a.data !== 16'h3CA5 || bus_a.rise !== 16'h3CA5) begin
               n_fail++;
               $display("FAIL first_third: data=%h rise=%h, required 3ca5/3ca5", bus_a.data, bus_a.rise);
            end
         end
         if (f >= 2) begin
            n_cmp++;
            if (cyc - last != PERIOD) begin
               n_fail++;
               $display("FAIL first_period frame %0d: %0d cycles, required %0d", f, cyc - last, PERIOD);
            end
         end
         last = cyc;
      end
   endtask

   task automatic test_pin_timing();
      logic [PERIOD-1:0] o_sh, o_ck, o_inh, o_fd, e_sh, e_ck, e_inh, e_fd;
      logic [W-1:0] s;
      for (int it = 0; it < 3; it++) begin
         pat_a = (it == 0) ? {8'h01, 8'h80} : (it == 1) ? {8'h2F, 8'hC1} : W'($urandom);
         s = pat_a;
         for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            o_sh[k] = bus_a.shldn; o_ck[k] = bus_a.srclk; o_inh[k] = bus_a.clk_inh; o_fd[k] = bus_a.frame_done;
            e_sh[k] = (k >= DV);
            e_inh[k] = !(k >= DV && k < DV + 2 * DV * BT);
            e_ck[k] = !e_inh[k] && ((((k - DV) / DV) % 2) == 1);
            e_fd[k] = (k == PERIOD - 1);
         end
         n_cmp++;
         if ({o_sh, o_ck, o_inh, o_fd} !== {e_sh, e_ck, e_inh, e_fd}) begin
            n_fail++;
            $display("FAIL pins_it%0d: shldn=%h srclk=%h clk_inh=%h fd=%h, required %h %h %h %h", it,
                     o_sh, o_ck, o_inh, o_fd, e_sh, e_ck, e_inh, e_fd);
         end
         ref_frame(0, DF, s);
         n_cmp++;
         if ({bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall} !== {s, m_data[0], m_rise[0], m_fall[0]}) begin
            n_fail++;
            $display("FAIL pins_frame%0d: raw/data/rise/fall %h/%h/%h/%h, required %h/%h/%h/%h", it,
                     bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall, s, m_data[0], m_rise[0], m_fall[0]);
         end
         if (it == 0) begin
            n_cmp++;
            if (bus_a.raw !== 16'h0180) begin
               n_fail++;
               $display("FAIL msb_first: raw=%h, required 0180", bus_a.raw);
            end
         end
      end
   endtask

   task automatic test_glitch();
      logic [W-1:0] seq[9];
      logic [W-1:0] s;
      bit ok;
      int falls;
      seq = '{16'h3CA5, 16'h3CA5, 16'h3CA5, 16'h3CA4, 16'h3CA4, 16'h3CA5, 16'h3CA4, 16'h3CA4, 16'h3CA4};
      falls = 0;
      for (int st = 0; st < 9; st++) begin
         pat_a = seq[st];
         s = seq[st];
         wait_fd(0, 2 * PERIOD, ok);
         n_cmp++;
         if (!ok) begin n_fail++; $display("FAIL glitch_timeout step %0d: no frame_done, required within %0d cycles", st, 2 * PERIOD); end
         ref_frame(0, DF, s);
         n_cmp++;
         if ({bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall} !== {s, m_data[0], m_rise[0], m_fall[0]}) begin
            n_fail++;
            $display("FAIL glitch_step%0d: raw/data/rise/fall %h/%h/%h/%h, required %h/%h/%h/%h", st,
                     bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall, s, m_data[0], m_rise[0], m_fall[0]);
         end
         if (st >= 3 && bus_a.fall[0] === 1'b1) falls++;
         if (st == 5) begin
            n_cmp++;
            if (falls != 0 || bus_a.data[0] !== 1'b1) begin
               n_fail++;
               $display("FAIL glitch_reject: falls=%0d data0=%b, required 0 and 1", falls, bus_a.data[0]);
            end
         end
      end
      n_cmp++;
      if (falls != 1 || bus_a.data[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_accept: falls=%0d data0=%b, required 1 and 0", falls, bus_a.data[0]);
      end
   endtask

   task automatic test_enable_drop();
      logic [W-1:0] s;
      bit ok;
      int c0, bad;
      s = W'($urandom);
      pat_a = s;
      c0 = cyc;
      repeat (10) @(negedge clk);
      bus_a.enable = 1'b0;
      wait_fd(0, PERIOD, ok);
      n_cmp++;
      if (!ok || cyc - c0 != PERIOD) begin
         n_fail++;
         $display("FAIL drop_finish: done=%b after %0d cycles, required 1 after %0d", ok, cyc - c0, PERIOD);
      end
      ref_frame(0, DF, s);
      n_cmp++;
      if ({bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall} !== {s, m_data[0], m_rise[0], m_fall[0]}) begin
         n_fail++;
         $display("FAIL drop_frame: raw/data/rise/fall %h/%h/%h/%h, required %h/%h/%h/%h",
                  bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall, s, m_data[0], m_rise[0], m_fall[0]);
      end
      bad = 0;
      for (int k = 0; k < 3 * PERIOD; k++) begin
         @(negedge clk);
         if ({bus_a.shldn, bus_a.srclk, bus_a.clk_inh, bus_a.frame_done} !== 4'b1010) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL drop_idle: %0d non-idle cycles, required 0", bad);
      end
      bus_a.enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] s;
      bit ok, seen;
      seen = 1'b0;
      for (int k = 0; k < 2 * PERIOD && !seen; k++) begin
         @(negedge clk);
         if (bus_a.clk_inh === 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin n_fail++; $display("FAIL rst_shift_timeout: clk_inh stayed %b, required 0 within %0d cycles", bus_a.clk_inh, 2 * PERIOD); end
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({bus_a.shldn, bus_a.srclk, bus_a.clk_inh, bus_a.frame_done} !== 4'b1010 ||
          {bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall} !== '0) begin
         n_fail++;
         $display("FAIL rst_async: pins %b%b%b fd=%b raw=%h data=%h, required 101 fd=0 zero",
                  bus_a.shldn, bus_a.srclk, bus_a.clk_inh, bus_a.frame_done, bus_a.raw, bus_a.data);
      end
      repeat (2) @(negedge clk);
      ref_reset(0);
      ref_reset(1);
      s = W'($urandom) | W'(1);
      pat_a = s;
      reset = 1'b0;
      for (int f = 1; f <= 3; f++) begin
         wait_fd(0, 2 * PERIOD, ok);
         n_cmp++;
         if (!ok) begin n_fail++; $display("FAIL rst_timeout frame %0d: no frame_done, required within %0d cycles", f, 2 * PERIOD); end
         ref_frame(0, DF, s);
         n_cmp++;
         if ({bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall} !== {s, m_data[0], m_rise[0], m_fall[0]}) begin
            n_fail++;
            $display("FAIL rst_frame%0d: raw/data/rise/fall %h/%h/%h/%h, required %h/%h/%h/%h", f,
                     bus_a.raw, bus_a.data, bus_a.rise, bus_a.fall, s, m_data[0], m_rise[0], m_fall[0]);
         end
      end
      n_cmp++;
      if (bus_a.data !== s || bus_a.rise !== s) begin
         n_fail++;
         $display("FAIL rst_third: data=%h rise=%h, required %h/%h", bus_a.data, bus_a.rise, s, s);
      end
   endtask

   task automatic test_df1();
      logic [W-1:0] s;
      bit ok;
      s = W'($urandom);
      pat_b = s;
      bus_b.enable = 1'b1;
      for (int f = 1; f <= 6; f++) begin
         wait_fd(1, 2 * PERIOD, ok);
         n_cmp++;
         if (!ok) begin n_fail++; $display("FAIL df1_timeout frame %0d: no frame_done, required within %0d cycles", f, 2 * PERIOD); end
         ref_frame(1, 1, s);
         n_cmp++;
         if ({bus_b.raw, bus_b.data, bus_b.rise, bus_b.fall} !== {s, m_data[1], m_rise[1], m_fall[1]}) begin
            n_fail++;
            $display("FAIL df1_frame%0d: raw/data/rise/fall %h/%h/%h/%h, required %h/%h/%h/%h", f,
                     bus_b.raw, bus_b.data, bus_b.rise, bus_b.fall, s, m_data[1], m_rise[1], m_fall[1]);
         end
         if (f >= 2) begin
            n_cmp++;
            if (bus_b.data !== bus_b.raw || bus_b.rise !== s || bus_b.fall !== ~s) begin
               n_fail++;
               $display("FAIL df1_track%0d: data=%h rise=%h fall=%h, required %h/%h/%h", f,
                        bus_b.data, bus_b.rise, bus_b.fall, s, s, ~s);
            end
         end
         s = ~s;
         pat_b = s;
      end
   endtask

   initial begin
      bus_a.enable = 1'b0;
      bus_b.enable = 1'b0;
      ref_reset(0);
      ref_reset(1);
      repeat (3) @(negedge clk);
      test_reset();
      test_first_frames();
      test_pin_timing();
      test_glitch();
      test_enable_drop();
      test_reset_mid();
      test_df1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, required finish earlier");
      $fatal(1, "watchdog expired");
   end
endmodule
